seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the 8-digit multiplexed seven-segment driver. It observes the active-low anode select and segment bus.
- Per digit: waits for the scan to settle, decodes the segment pattern back to a hex nibble, and assembles a 32-bit word.
- Publishes the word once all 8 digits are captured in a frame.
- Used for display loopback self-test and for capturing scanned displays from external boards.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_pattern_decode.sv | 23 ++
 rtl/seg7_scan_decoder.sv | 120 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern table, special patterns, scan-decoder
// FSM states and anode-select helpers.
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F, identical to the driver's.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CAPTURE,
    ST_HOLD
  } scan_state_t;

  function automatic logic is_onehot_low(input logic [7:0] an);
    logic [7:0] lit;
    lit = ~an;
    return (lit != 8'h00) && ((lit & (lit - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [2:0] low_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> nibble, with an
// error flag for any pattern that is not one of the 16 hex glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    o_nibble = '0;
    o_err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_LUT[i]) begin
        o_nibble = 4'(i);
        o_err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the 32-bit word shown on an 8-digit multiplexed display by watching
// its anode and segment buses; publishes a word once every digit has been captured.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 11
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  output logic [31:0] x,
  output logic        frame_valid,
  output logic        x_valid,
  output logic [7:0]  digit_err,
  output logic        an_err
);

  logic [7:0]       r_an, r_an_d;
  logic [6:0]       r_seg, r_seg_d;
  logic [CNT_W-1:0] r_cnt;
  scan_state_t      r_state, w_next;
  logic [31:0]      r_shadow, r_x;
  logic [7:0]       r_shadow_err, r_seen, r_digit_err;
  logic             r_frame_valid, r_x_valid, r_an_err;

  logic       w_changed, w_an_ok, w_an_bad, w_settled, w_capture;
  logic [2:0] w_idx;
  logic [3:0] w_nibble;
  logic       w_err;

  assign w_changed = {r_an, r_seg} != {r_an_d, r_seg_d};
  assign w_an_ok   = is_onehot_low(r_an);
  assign w_an_bad  = !w_an_ok && (r_an != 8'hFF);
  assign w_settled = r_cnt == CNT_W'(SETTLE_CYCLES - 1);
  assign w_idx     = low_index(r_an);
  // A change seen in CAPTURE means the pattern was not the one that settled; drop it.
  assign w_capture = (r_state == ST_CAPTURE) && !w_changed && !w_an_bad;

  seg7_pattern_decode u_decode (
    .i_seg    (r_seg),
    .o_nibble (w_nibble),
    .o_err    (w_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_an    <= 8'hFF;
      r_seg   <= SEG_BLANK;
      r_an_d  <= 8'hFF;
      r_seg_d <= SEG_BLANK;
      r_state <= ST_WAIT;
    end else begin
      r_an    <= an;
      r_seg   <= seg;
      r_an_d  <= r_an;
      r_seg_d <= r_seg;
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_an_bad) begin
      w_next = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT:    if (w_settled && !w_changed && w_an_ok) w_next = ST_CAPTURE;
        ST_CAPTURE: w_next = w_changed ? ST_WAIT : ST_HOLD;
        ST_HOLD:    if (w_changed) w_next = ST_WAIT;
        default:    w_next = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr || r_state != ST_WAIT || w_changed || w_an_bad) begin
      r_cnt <= '0;
    end else if (!w_settled) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // NOTE: the shadow word is an ordinary register bank, so clr clears it; a partial frame must not leak into the next.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_shadow      <= '0;
      r_shadow_err  <= '0;
      r_seen        <= '0;
      r_x           <= '0;
      r_digit_err   <= '0;
      r_frame_valid <= 1'b0;
      r_x_valid     <= 1'b0;
      r_an_err      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_an_bad) r_an_err <= 1'b1;
      if (r_seen == 8'hFF) begin
        r_x           <= r_shadow;
        r_digit_err   <= r_shadow_err;
        r_seen        <= '0;
        r_frame_valid <= 1'b1;
        r_x_valid     <= 1'b1;
      end else if (w_capture) begin
        r_shadow[{w_idx, 2'b00} +: 4] <= w_nibble;
        r_shadow_err[w_idx]           <= w_err;
        r_seen[w_idx]                 <= 1'b1;
      end
    end
  end

  assign x           = r_x;
  assign frame_valid = r_frame_valid;
  assign x_valid     = r_x_valid;
  assign digit_err   = r_digit_err;
  assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: emulates a scanning driver (segment data one
// clock behind the anode) and scoreboards every published frame.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 16;
  localparam int HOLD_N = 40;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  err;
  } frame_t;

  logic        clk, clr;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] x;
  logic        frame_valid, x_valid, an_err;
  logic [7:0]  digit_err;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     n_frames = 0;
  int     snap;

  logic [6:0] tb_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_W(5)) dut (
    .clk         (clk),
    .clr         (clr),
    .an          (an),
    .seg         (seg),
    .x           (x),
    .frame_valid (frame_valid),
    .x_valid     (x_valid),
    .digit_err   (digit_err),
    .an_err      (an_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every frame_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!clr && frame_valid) begin
      n_frames++;
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        frame_t f;
        f = exp_q.pop_front();
        check("frame_x", x, f.word);
        check("frame_digit_err", 32'(digit_err), 32'(f.err));
        check("frame_x_valid", 32'(x_valid), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Driver emulation: anode switches first, segment data follows one clock later.
  task automatic show(input int k, input logic [6:0] p, input int n);
    tick(1);
    an = ~(8'h01 << k);
    tick(1);
    seg = p;
    tick(n);
  endtask

  task automatic scan_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) show(i, tb_seg[w[4*i +: 4]], HOLD_N);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick(1);
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    clr = 1'b1;
    an  = 8'hFF;
    seg = 7'h7F;
    tick(3);
    clr = 1'b0;
    tick(1);
    check("reset_x", x, 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_x_valid", 32'(x_valid), 32'd0);
    check("reset_digit_err", 32'(digit_err), 32'd0);
    check("reset_an_err", 32'(an_err), 32'd0);

    // Straight loopback of a full word.
    exp_q.push_back('{32'h1234ABCD, 8'h00});
    scan_word(32'h1234ABCD);
    wait_drain("loopback_drain");
    check("loopback_x", x, 32'h1234ABCD);
    check("loopback_x_valid", 32'(x_valid), 32'd1);

    // Digit 3 shows a dash.
    exp_q.push_back('{32'h77770777, 8'h08});
    for (int i = 0; i < 8; i++) show(i, (i == 3) ? 7'h3F : tb_seg[7], HOLD_N);
    wait_drain("dash_drain");
    check("dash_digit_err", 32'(digit_err), 32'h08);

    // Toggling faster than the settle window must never capture digits 0/1.
    snap = n_frames;
    for (int r = 0; r < 12; r++) begin
      an = 8'hFE; seg = tb_seg[8]; tick(8);
      an = 8'hFD; seg = tb_seg[9]; tick(8);
    end
    for (int i = 2; i < 8; i++) show(i, tb_seg[5], HOLD_N);
    tick(30);
    check("toggle_no_frame", 32'(n_frames), 32'(snap));
    exp_q.push_back('{32'h55555555, 8'h00});
    show(0, tb_seg[5], HOLD_N);
    show(1, tb_seg[5], HOLD_N);
    wait_drain("toggle_drain");

    // Invalid anode pattern sets a sticky error that survives valid frames.
    tick(1);
    an = 8'b1111_0011;
    tick(3);
    an = 8'hFF;
    tick(3);
    check("an_err_set", 32'(an_err), 32'd1);
    exp_q.push_back('{32'h89ABCDEF, 8'h00});
    scan_word(32'h89ABCDEF);
    wait_drain("an_err_drain");
    check("an_err_sticky", 32'(an_err), 32'd1);
    do_clr();
    check("an_err_clr", 32'(an_err), 32'd0);
    check("clr_x_valid", 32'(x_valid), 32'd0);

    // clr mid-frame discards the partial shadow.
    for (int i = 0; i < 5; i++) show(i, tb_seg[1], HOLD_N);
    an = 8'hFF;
    seg = 7'h7F;
    tick(2);
    do_clr();
    check("midclr_x", x, 32'h0);
    snap = n_frames;
    exp_q.push_back('{32'hCAFEF00D, 8'h00});
    scan_word(32'hCAFEF00D);
    wait_drain("midclr_drain");
    check("midclr_one_frame", 32'(n_frames), 32'(snap + 1));
    check("midclr_x", x, 32'hCAFEF00D);

    // Out-of-order scan with digit 0 re-shown before the frame completes.
    snap = n_frames;
    exp_q.push_back('{32'h7654321E, 8'h00});
    show(0, tb_seg[5], HOLD_N);
    show(1, tb_seg[1], HOLD_N);
    show(2, tb_seg[2], HOLD_N);
    show(0, tb_seg[14], HOLD_N);
    for (int i = 3; i < 8; i++) show(i, tb_seg[i], HOLD_N);
    wait_drain("reorder_drain");
    check("reorder_one_frame", 32'(n_frames), 32'(snap + 1));
    check("reorder_nibble0", 32'(x[3:0]), 32'hE);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
